hamming_enc_engine: RTL and testbench
=====================================

HAMMING_ENC_ENGINE -- requirements
Module: hamming_enc_engine

Interface
REQ-001 SHALL have parameter NUM_MSG, default 15, meaning messages encoded per request.
REQ-002 SHALL have parameter IN_BASE, default 0, meaning data-memory byte address of message 0 LSB.
REQ-003 SHALL have parameter OUT_BASE, default 30, meaning data-memory byte address of codeword 0 LSB.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  start request, level-sampled.
REQ-007 SHALL have port done  output  1  registered; high when the run is complete.
REQ-008 SHALL have port mem_addr  output  8  byte address to data memory.
REQ-009 SHALL have port mem_wr_en  output  1  write strobe; the write occurs on the next rising edge.
REQ-010 SHALL have port mem_wdata  output  8  write data.
REQ-011 SHALL have port mem_rdata  input  8  combinational read data for the current mem_addr.

Function
REQ-012 SHALL implement states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE, one clock per state.
REQ-013 SHALL move IDLE->RD_LO on a rising edge with req=1; in all other states, req SHALL NOT affect the sequence until DONE is reached.
REQ-014 SHALL, in RD_LO, drive mem_addr=IN_BASE+2i and latch mem_rdata as d[8:1], with i being the message index (0..NUM_MSG-1).
REQ-015 SHALL, in RD_HI, drive mem_addr=IN_BASE+2i+1 and latch mem_rdata[2:0] as d[11:9]; mem_rdata[7:3] SHALL be ignored.
REQ-016 SHALL compute parity from the latched message:
- p8=^d[11:5]
- p4=^d[11:8]^d[4]^d[3]^d[2]
- p2=d11^d10^d7^d6^d4^d3^d1
- p1=d11^d9^d7^d5^d4^d2^d1
- p0=^d[11:1]^p8^p4^p2^p1
REQ-017 SHALL form codeword cw[15:0]={d[11:5],p8,d[4:2],p4,d1,p2,p1,p0}.
REQ-018 SHALL, in WR_LO, drive mem_addr=OUT_BASE+2i, mem_wdata=cw[7:0], mem_wr_en=1.
REQ-019 SHALL, in WR_HI, drive mem_addr=OUT_BASE+2i+1, mem_wdata=cw[15:8], mem_wr_en=1.
REQ-020 SHALL, on leaving WR_HI, go to RD_LO with i+1 if i<NUM_MSG-1, else to DONE.
REQ-021 SHALL drive mem_wr_en=0 in IDLE, RD_LO, RD_HI and DONE; mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.
REQ-022 SHALL take exactly 4*NUM_MSG cycles from RD_LO entry to DONE entry; done SHALL be high iff state==DONE.
REQ-023 SHALL hold DONE while req=1 and return to IDLE on the first edge with req=0; done SHALL fall with that transition.
REQ-024 SHALL compute the index and address arithmetic modulo 256 (8-bit wrap) with no overflow detection.
REQ-025 SHALL clear the message index to 0 on every IDLE->RD_LO transition.

Reset
REQ-026 SHALL, while reset=0, immediately force state=IDLE, i=0, latched message=0, done=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, regardless of clk.
REQ-027 SHALL, on reset assertion mid-run, abort the run without completing a partial write; already-written codewords remain in memory.
REQ-028 SHALL start no run until reset=1 and a subsequent edge with req=1.

Verification
REQ-029 SHALL cover message 11'h000 -> bytes OUT_BASE/OUT_BASE+1 = 8'h00/8'h00.
REQ-030 SHALL cover message 11'h7FF -> codeword 16'hFFFF (LSB 8'hFF, MSB 8'hFF).
REQ-031 SHALL cover message 11'h001 -> 16'h000F, and 11'h010 -> 16'h0303.
REQ-032 SHALL cover input high byte 8'hF8 with low byte 8'h00 (bits [7:3] set) -> codeword 16'h0000.
REQ-033 SHALL cover a full run with NUM_MSG=15 and a 1-cycle req pulse -> done high exactly 60 cycles after RD_LO entry, 30 bytes written at 30..59, and done low one cycle after req=0.
REQ-034 SHALL cover reset=0 asserted during WR_LO of message 7 -> mem_wr_en=0 at once, codewords 0..6 intact, byte 44 unwritten, and a fresh req re-encodes from message 0.

Source files
------------

// File: rtl/hamming_enc_engine.sv
// Memory-to-memory extended Hamming(16,11) encoder: reads NUM_MSG 11-bit messages
// as byte pairs, writes SECDED codewords back as byte pairs, then raises done.
module hamming_enc_engine #(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [2:0] dbg_state_o
);

    // Handshake: req is level-sampled only in IDLE (start) and DONE (release);
    // a memory write happens on the rising edge that ends a cycle with mem_wr_en=1.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] IN_B     = IN_BASE[7:0];
    localparam logic [7:0] OUT_B    = OUT_BASE[7:0];
    localparam logic [7:0] LAST_IDX = 8'(NUM_MSG - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [10:0] msg_q, msg_d;
    logic        done_q;

    logic [7:0]  idx2;
    logic [7:0]  rd_addr;
    logic [7:0]  wr_addr;
    logic        p8, p4, p2, p1, p0;
    logic [15:0] cw;

    // msg_q[k] holds message bit d[k+1]
    assign p8 = ^msg_q[10:4];
    assign p4 = ^msg_q[10:7] ^ msg_q[3] ^ msg_q[2] ^ msg_q[1];
    assign p2 = msg_q[10] ^ msg_q[9] ^ msg_q[6] ^ msg_q[5] ^ msg_q[3] ^ msg_q[2] ^ msg_q[0];
    assign p1 = msg_q[10] ^ msg_q[8] ^ msg_q[6] ^ msg_q[4] ^ msg_q[3] ^ msg_q[1] ^ msg_q[0];
    assign p0 = ^msg_q ^ p8 ^ p4 ^ p2 ^ p1;
    assign cw = {msg_q[10:4], p8, msg_q[3:1], p4, msg_q[0], p2, p1, p0};

    assign idx2    = {idx_q[6:0], 1'b0};
    assign rd_addr = IN_B + idx2;
    assign wr_addr = OUT_B + idx2;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        msg_d     = msg_q;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_wr_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_RD_LO;
                    idx_d   = 8'h00;
                end
            end
            S_RD_LO: begin
                mem_addr   = rd_addr;
                msg_d[7:0] = mem_rdata;
                state_d    = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr    = rd_addr + 8'd1;
                msg_d[10:8] = mem_rdata[2:0];
                state_d     = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr  = wr_addr;
                mem_wdata = cw[7:0];
                mem_wr_en = 1'b1;
                state_d   = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr  = wr_addr + 8'd1;
                mem_wdata = cw[15:8];
                mem_wr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_RD_LO;
                end
            end
            S_DONE: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'h00;
            msg_q   <= 11'h000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Bench for hamming_enc_engine: table vectors, random runs against a positional
// Hamming model, held-req and mid-run reset sequences.
module tb_hamming_enc_engine;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 0;
    localparam int OUT_BASE = 30;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       req   = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    hamming_enc_engine #(
        .NUM_MSG (NUM_MSG),
        .IN_BASE (IN_BASE),
        .OUT_BASE(OUT_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dbg_state_o(dbg_state)
    );

    // input region is bench-owned; output region is written only by the DUT
    logic [7:0]  in_mem [256];
    logic [7:0]  out_mem[256];
    logic        written[256];
    logic        clr_out = 1'b0;
    logic [15:0] wr_log[$];

    assign mem_rdata = in_mem[mem_addr];

    always @(posedge clk) begin
        if (clr_out) begin
            for (int i = 0; i < 256; i++) begin
                out_mem[i] <= 8'h00;
                written[i] <= 1'b0;
            end
        end else if (mem_wr_en) begin
            out_mem[mem_addr] <= mem_wdata;
            written[mem_addr] <= 1'b1;
            wr_log.push_back({mem_addr, mem_wdata});
        end
    end

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] cw;
    } vec_t;

    vec_t        tbl[NUM_MSG];
    logic [7:0]  lo_a[NUM_MSG];
    logic [7:0]  hi_a[NUM_MSG];
    logic [15:0] cw_a[NUM_MSG];
    logic [15:0] exp_q[$];
    int          rd_ptr = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    // Textbook layout: data in non-power-of-two positions 3..15, parity at 2^k
    // covering positions with bit k set, bit 0 is overall parity.
    function automatic logic [15:0] ref_cw(input logic [7:0] lo, input logic [7:0] hi);
        logic [10:0] m;
        logic [15:0] c;
        logic        par;
        int          k;
        m = {hi[2:0], lo};
        c = 16'h0000;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos[3:0]] = m[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) == 1) par = par ^ c[pos[3:0]];
            c[1 << b] = par;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_out();
        clr_out = 1'b1;
        tick();
        clr_out = 1'b0;
    endtask

    task automatic load_inputs();
        for (int i = 0; i < NUM_MSG; i++) begin
            in_mem[IN_BASE + 2*i]     = lo_a[i];
            in_mem[IN_BASE + 2*i + 1] = hi_a[i];
        end
    endtask

    task automatic expect_writes(input int nmsg);
        for (int i = 0; i < nmsg; i++) begin
            exp_q.push_back({8'(OUT_BASE + 2*i), cw_a[i][7:0]});
            exp_q.push_back({8'(OUT_BASE + 2*i + 1), cw_a[i][15:8]});
        end
    endtask

    task automatic check_writes(input string tag);
        logic [15:0] e;
        while (rd_ptr < wr_log.size()) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s unexpected write", tag), {16'h0, wr_log[rd_ptr]}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s write addr/data", tag), {16'h0, wr_log[rd_ptr]}, {16'h0, e});
            end
            rd_ptr++;
        end
        check($sformatf("%s missing writes", tag), exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_out(input string tag, input int nmsg);
        for (int i = 0; i < nmsg; i++) begin
            check($sformatf("%s cw%0d lo", tag, i), {24'h0, out_mem[OUT_BASE + 2*i]}, {24'h0, cw_a[i][7:0]});
            check($sformatf("%s cw%0d hi", tag, i), {24'h0, out_mem[OUT_BASE + 2*i + 1]}, {24'h0, cw_a[i][15:8]});
        end
    endtask

    task automatic run_full(input string tag, input bit hold_req);
        int n;
        clear_out();
        load_inputs();
        expect_writes(NUM_MSG);
        req = 1'b1;
        tick();
        if (!hold_req) req = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check($sformatf("%s cycles RD_LO->DONE", tag), n, 4*NUM_MSG);
        if (hold_req) begin
            repeat (3) tick();
            check($sformatf("%s done held", tag), {31'h0, done}, 1);
            req = 1'b0;
        end
        tick();
        check($sformatf("%s done falls", tag), {31'h0, done}, 0);
        check($sformatf("%s idle wr_en", tag), {31'h0, mem_wr_en}, 0);
        check($sformatf("%s idle addr", tag), {24'h0, mem_addr}, 0);
        check_writes(tag);
        check_out(tag, NUM_MSG);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) in_mem[i] = 8'h00;

        // reset state, and req during reset must not start a run
        req = 1'b1;
        #3;
        check("reset done", {31'h0, done}, 0);
        check("reset wr_en", {31'h0, mem_wr_en}, 0);
        check("reset addr", {24'h0, mem_addr}, 0);
        check("reset wdata", {24'h0, mem_wdata}, 0);
        repeat (3) tick();
        check("reset held wr_en", {31'h0, mem_wr_en}, 0);
        req = 1'b0;
        reset = 1'b1;
        repeat (4) tick();
        check("no run without req", wr_log.size(), rd_ptr);
        check("idle done", {31'h0, done}, 0);

        // table vectors: boundary messages plus random fill
        tbl[0] = '{8'h00, 8'h00, 16'h0000};
        tbl[1] = '{8'hFF, 8'h07, 16'hFFFF};
        tbl[2] = '{8'h01, 8'h00, 16'h000F};
        tbl[3] = '{8'h10, 8'h00, 16'h0303};
        tbl[4] = '{8'h00, 8'hF8, 16'h0000};
        tbl[5] = '{8'hFF, 8'hFF, 16'hFFFF};
        for (int i = 6; i < NUM_MSG; i++) begin
            tbl[i].lo = 8'($urandom_range(0, 255));
            tbl[i].hi = 8'($urandom_range(0, 255));
            tbl[i].cw = ref_cw(tbl[i].lo, tbl[i].hi);
        end
        for (int i = 0; i < NUM_MSG; i++) begin
            lo_a[i] = tbl[i].lo;
            hi_a[i] = tbl[i].hi;
            cw_a[i] = tbl[i].cw;
        end
        run_full("table", 1'b0);

        // random runs, one with req held through DONE
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_MSG; i++) begin
                lo_a[i] = 8'($urandom_range(0, 255));
                hi_a[i] = 8'($urandom_range(0, 255));
                cw_a[i] = ref_cw(lo_a[i], hi_a[i]);
            end
            run_full($sformatf("rand%0d", r), r == 1);
        end

        // reset during WR_LO of message 7
        clear_out();
        load_inputs();
        expect_writes(7);
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (30) tick();
        check("abort pre addr", {24'h0, mem_addr}, OUT_BASE + 14);
        check("abort pre wr_en", {31'h0, mem_wr_en}, 1);
        reset = 1'b0;
        #1;
        check("abort wr_en", {31'h0, mem_wr_en}, 0);
        check("abort addr", {24'h0, mem_addr}, 0);
        check("abort wdata", {24'h0, mem_wdata}, 0);
        check("abort done", {31'h0, done}, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check_writes("abort");
        check_out("abort", 7);
        check("abort byte44 unwritten", {31'h0, written[OUT_BASE + 14]}, 0);
        check("abort byte45 unwritten", {31'h0, written[OUT_BASE + 15]}, 0);
        run_full("rerun", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
